// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants and shared fetch-unit types
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_J      = 6'h02;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // J-type target: upper nibble comes from pc+4 so a carry out of bit 27 is honoured
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
        return ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_queue.sv
// rtl/ifu_queue.sv - in-order FIFO of fetched (pc, word) entries with push/pop/clear
module ifu_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - credit-limited fetch front end with redirect/flush; IFU_PERF_EN adds perf counters
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] branch_target
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    ifu_state_e    state, state_n;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target;
    logic [CW-1:0] inflight, inflight_n;
    logic [CW-1:0] drop, drop_n;
    logic [CW-1:0] qcount, qcount_n;
    logic          req_valid_q;
    logic          req_valid_n;
    logic          accept, pop, redirect, push;
    logic          q_empty;
    fetch_entry_t  head;

    assign accept   = req_valid_q & imem_req_ready;
    assign pop      = ~q_empty & instr_ready;
    assign redirect = pop & (jump | pcsrc);
    // The response landing in a redirect cycle belongs to the wrong path
    assign push     = imem_rsp_valid & (drop == '0) & ~redirect;
    assign target   = jump ? jump_target(head.pc, head.word[25:0]) : branch_target;

    always_comb begin
        inflight_n = inflight + CW'(accept) - CW'(imem_rsp_valid);
        qcount_n   = redirect ? '0 : qcount + CW'(push) - CW'(pop);
        drop_n     = drop;
        if (redirect)
            drop_n = inflight_n;
        else if (imem_rsp_valid && drop != '0)
            drop_n = drop - 1'b1;
        state_n     = (drop_n != '0) ? FLUSH : FETCH;
        req_valid_n = (state_n == FETCH) &&
                      (({1'b0, inflight_n} + {1'b0, qcount_n}) < (CW + 1)'(QDEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
            rsp_pc      <= RESET_PC & 32'hFFFF_FFFC;
            inflight    <= '0;
            drop        <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            inflight    <= inflight_n;
            drop        <= drop_n;
            req_valid_q <= req_valid_n;
            if (redirect) begin
                fetch_pc <= target & 32'hFFFF_FFFC;
                rsp_pc   <= target & 32'hFFFF_FFFC;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (push)   rsp_pc   <= rsp_pc + 32'd4;
            end
        end
    end

    ifu_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: rsp_pc, word: imem_rsp_data}),
        .pop       (pop),
        .clear     (redirect),
        .head      (head),
        .count     (qcount),
        .empty     (q_empty)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;
    assign instr_valid    = ~q_empty;
    assign instr          = head.word;
    assign instr_pc       = head.pc;
    assign op             = head.word[31:26];
    assign funct          = head.word[5:0];

`ifdef IFU_PERF_EN
    // Flushed = entries behind the popped redirect plus every discarded response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            if (redirect)
                perf_flushed <= perf_flushed + 32'(qcount) - 32'd1 + 32'(imem_rsp_valid);
            else if (imem_rsp_valid && drop != '0)
                perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [5:0]  op, funct;
    logic        pcsrc, jump;
    logic [31:0] branch_target;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct(funct), .pcsrc(pcsrc), .jump(jump), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory model and architectural stream model
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] ovr[logic [31:0]];
    bit          br[logic [31:0]];
    bit          jp[logic [31:0]];
    logic [31:0] bt[logic [31:0]];
    bit          seen[logic [31:0]];
    int          cyc = 0, lat = 1, rdy_pct = 100, irdy_pct = 100;
    bit          directed = 1'b1, force_stall = 1'b0, first_acc = 1'b1, mon_req = 1'b0;
    int          npops = 0, req_cnt = 0, nacc = 0;
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ (a >> 7);
    endfunction

    task automatic step();
        logic [31:0] w, pc4, tgt_b, rdata;
        bit irdy, pop, do_j, do_b, rspv, rdy;
        w = '0;
        @(negedge clk);
        cyc++;
        if (instr_valid) begin
            w = word_at(exp_pc);
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instr", instr, w);
            check_eq("op", {26'd0, op}, {26'd0, w[31:26]});
            check_eq("funct", {26'd0, funct}, {26'd0, w[5:0]});
            seen[instr_pc] = 1'b1;
        end
        irdy = force_stall ? 1'b0 : ($urandom_range(99) < irdy_pct);
        pop  = instr_valid && irdy;
        if (pop) begin
            if (directed) begin
                do_j  = jp.exists(exp_pc);
                do_b  = br.exists(exp_pc);
                tgt_b = bt.exists(exp_pc) ? bt[exp_pc] : 32'h0;
            end else begin
                do_j  = ($urandom_range(99) < 8);
                do_b  = ($urandom_range(99) < 12);
                tgt_b = $urandom & 32'h0000_3FFC;
            end
            pc4 = exp_pc + 32'd4;
            if (do_j)      exp_pc = {pc4[31:28], w[25:0], 2'b00};
            else if (do_b) exp_pc = tgt_b;
            else           exp_pc = pc4;
            npops++;
        end else begin
            do_j  = 1'($urandom);
            do_b  = 1'($urandom);
            tgt_b = $urandom;
        end
        rspv  = 1'b0;
        rdata = $urandom;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            rspv  = 1'b1;
            rdata = word_at(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (mon_req && imem_req_valid) req_cnt++;
        rdy = ($urandom_range(99) < rdy_pct);
        if (imem_req_valid && rdy) begin
            check_eq("addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
            if (first_acc) begin
                check_eq("first_addr", imem_req_addr, RESET_PC);
                first_acc = 1'b0;
            end
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            nacc++;
            check_eq("credit", 32'(pend_addr.size() <= QDEPTH), 32'd1);
        end
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rdata;
        instr_ready    = irdy;
        pcsrc          = do_b;
        jump           = do_j;
        branch_target  = tgt_b;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        check_eq("rst_op_funct", {20'd0, op, funct}, 32'd0);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0;
        pcsrc = 1'b0; jump = 1'b0;
        pend_addr.delete(); pend_due.delete(); seen.delete();
        exp_pc = RESET_PC; first_acc = 1'b1; npops = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acc0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0; branch_target = '0;
        @(negedge clk);

        // Sequential stream, then decode backpressure
        do_reset();
        run(40);
        check_eq("progress_seq", 32'(npops >= 25), 32'd1);
        force_stall = 1'b1;
        acc0 = nacc;
        run(4);
        mon_req = 1'b1; req_cnt = 0;
        run(4);
        mon_req = 1'b0;
        check_eq("stall_req_stopped", req_cnt, 32'd0);
        check_eq("stall_accepts", 32'(nacc - acc0 <= QDEPTH), 32'd1);
        check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
        force_stall = 1'b0;
        run(20);

        // Taken branch at 0x8 to 0x40
        do_reset();
        br[32'h8] = 1'b1; bt[32'h8] = 32'h40;
        run(30);
        check_eq("br_seen_40", 32'(seen.exists(32'h40)), 32'd1);
        check_eq("br_skip_c", 32'(seen.exists(32'hC)), 32'd0);
        check_eq("br_skip_10", 32'(seen.exists(32'h10)), 32'd0);

        // J at 0x10 with pcsrc also set: jump wins
        do_reset();
        br.delete(); bt.delete();
        ovr[32'h10] = {OP_J, 26'h100};
        jp[32'h10] = 1'b1; br[32'h10] = 1'b1; bt[32'h10] = 32'h80;
        run(30);
        check_eq("j_seen_400", 32'(seen.exists(32'h400)), 32'd1);
        check_eq("j_skip_14", 32'(seen.exists(32'h14)), 32'd0);
        check_eq("j_skip_80", 32'(seen.exists(32'h80)), 32'd0);

        // Slow memory: redirect with words in flight must flush them
        do_reset();
        ovr.delete(); jp.delete(); br.delete(); bt.delete();
        lat = 3;
        br[32'h4] = 1'b1; bt[32'h4] = 32'h100;
        run(40);
        check_eq("flush_seen_100", 32'(seen.exists(32'h100)), 32'd1);
        check_eq("flush_skip_8", 32'(seen.exists(32'h8)), 32'd0);
        check_eq("flush_progress", 32'(npops >= 8), 32'd1);

        // Randomized traffic with a mid-burst reset in each latency setting
        directed = 1'b0; br.delete(); bt.delete();
        rdy_pct = 70; irdy_pct = 70;
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            do_reset();
            run(150);
            check_eq("rand_progress_a", 32'(npops >= 15), 32'd1);
            do_reset();
            run(150);
            check_eq("rand_progress_b", 32'(npops >= 15), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
